timing_g_pipe: RTL and testbench



---
 rtl/timing_g_pipe.sv | 105 ++++++++++
 tb/tb_timing_g_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timing_g_pipe.sv
// Clocked three-gate path model y = ((a & b) | c) & d with per-gate transport
// latency, plus settle, y-transition and static-hazard observation.
module timing_g_pipe #(
  parameter int WIDTH  = 4,
  parameter int D_AND1 = 2,
  parameter int D_OR   = 3,
  parameter int D_AND2 = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             clr,
  output logic [WIDTH-1:0] n1,
  output logic [WIDTH-1:0] n2,
  output logic [WIDTH-1:0] y,
  output logic             settled,
  output logic [CNT_W-1:0] y_toggles,
  output logic             hazard
);

  localparam int L  = D_AND1 + D_OR + D_AND2;
  localparam int SW = $clog2(L + 1);
  localparam logic [SW-1:0] L_CNT = SW'(L);
  localparam int IW = 4 * WIDTH;

  logic [WIDTH-1:0] g1_q [D_AND1];
  logic [WIDTH-1:0] g1_d [D_AND1];
  logic [WIDTH-1:0] g2_q [D_OR];
  logic [WIDTH-1:0] g2_d [D_OR];
  logic [WIDTH-1:0] g3_q [D_AND2];
  logic [WIDTH-1:0] g3_d [D_AND2];

  logic [IW-1:0]    prev_q, prev_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic             haz_q, haz_d;
  logic             win_q, win_d;
  logic [IW-1:0]    in_vec;
  logic             in_change;
  logic             y_change;

  // Each gate is a pure shift register: stage 0 evaluates the gate on the
  // current inputs / upstream tap, so every pulse survives unfiltered.
  always_comb begin
    g1_d[0] = a & b;
    for (int i = 1; i < D_AND1; i++) g1_d[i] = g1_q[i-1];
    g2_d[0] = g1_q[D_AND1-1] | c;
    for (int i = 1; i < D_OR; i++) g2_d[i] = g2_q[i-1];
    g3_d[0] = g2_q[D_OR-1] & d;
    for (int i = 1; i < D_AND2; i++) g3_d[i] = g3_q[i-1];
  end

  assign n1 = g1_q[D_AND1-1];
  assign n2 = g2_q[D_OR-1];
  assign y  = g3_q[D_AND2-1];

  // A y change is detected on the edge that updates y, so an input change on
  // that same edge cannot be its cause and rightly opens a clean window.
  always_comb begin
    in_vec    = {a, b, c, d};
    in_change = (in_vec != prev_q);
    y_change  = (g3_d[D_AND2-1] != g3_q[D_AND2-1]);
    prev_d    = in_vec;
    cnt_d     = in_change ? '0 : ((cnt_q == L_CNT) ? cnt_q : cnt_q + SW'(1));
    tog_d     = tog_q;
    haz_d     = haz_q | (y_change & ~in_change & win_q);
    win_d     = in_change ? 1'b0 : (win_q | y_change);
    if (y_change && (tog_q != '1)) tog_d = tog_q + CNT_W'(1);
    if (clr) begin
      tog_d = '0;
      haz_d = 1'b0;
    end
  end

  assign settled   = (cnt_q == L_CNT);
  assign y_toggles = tog_q;
  assign hazard    = haz_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < D_AND1; i++) g1_q[i] <= '0;
      for (int i = 0; i < D_OR; i++)   g2_q[i] <= '0;
      for (int i = 0; i < D_AND2; i++) g3_q[i] <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
      tog_q  <= '0;
      haz_q  <= 1'b0;
      win_q  <= 1'b0;
    end else begin
      for (int i = 0; i < D_AND1; i++) g1_q[i] <= g1_d[i];
      for (int i = 0; i < D_OR; i++)   g2_q[i] <= g2_d[i];
      for (int i = 0; i < D_AND2; i++) g3_q[i] <= g3_d[i];
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      tog_q  <= tog_d;
      haz_q  <= haz_d;
      win_q  <= win_d;
    end
  end

endmodule

// File: tb/tb_timing_g_pipe.sv
// Bench for timing_g_pipe: a history-indexed reference model feeds a
// scoreboard queue every cycle, with directed checkpoints along the way.
module tb_timing_g_pipe;

   localparam int DA1 = 2;
   localparam int DOR = 3;
   localparam int DA2 = 2;
   localparam int LAT = DA1 + DOR + DA2;

   logic       clk = 1'b0;
   logic       reset;
   logic [0:0] a, b, c, d;
   logic       clr;
   logic [0:0] n1, n2, y;
   logic       settled;
   logic [7:0] yToggles;
   logic       hazard;

   logic [1:0] sa, sb, sc, sd;
   logic       sClr;
   logic [1:0] sN1, sN2, sY;
   logic       sSettled;
   logic [1:0] sToggles;
   logic       sHazard;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       n1;
      logic       n2;
      logic       y;
      logic       settled;
      logic [7:0] tog;
      logic       haz;
   } exp_t;

   exp_t scoreboard[$];

   // Model state: per-edge input history plus the observation counters
   logic histAb[0:4095];
   logic histC[0:4095];
   logic histD[0:4095];
   int   edgeIdx;
   logic [3:0] prevIn;
   int   settleCnt;
   logic yPrev;
   int   togModel;
   logic hazModel;
   logic winModel;

   // Free-running clock shared by both instances
   always #5 clk = ~clk;

   timing_g_pipe #(.WIDTH(1), .D_AND1(DA1), .D_OR(DOR), .D_AND2(DA2), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d), .clr(clr),
      .n1(n1), .n2(n2), .y(y), .settled(settled), .y_toggles(yToggles), .hazard(hazard)
   );

   timing_g_pipe #(.WIDTH(2), .D_AND1(DA1), .D_OR(DOR), .D_AND2(DA2), .CNT_W(2)) dutSat (
      .clk(clk), .reset(reset), .a(sa), .b(sb), .c(sc), .d(sd), .clr(sClr),
      .n1(sN1), .n2(sN2), .y(sY), .settled(sSettled), .y_toggles(sToggles), .hazard(sHazard)
   );

   // One comparison point; counts and reports any mismatch
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic abAt(int t);
      return (t < 0) ? 1'b0 : histAb[t];
   endfunction

   function automatic logic cAt(int t);
      return (t < 0) ? 1'b0 : histC[t];
   endfunction

   function automatic logic dAt(int t);
      return (t < 0) ? 1'b0 : histD[t];
   endfunction

   // Forget all history, as the DUT does on reset
   task automatic modelReset();
      edgeIdx   = 0;
      prevIn    = 4'b0000;
      settleCnt = 0;
      yPrev     = 1'b0;
      togModel  = 0;
      hazModel  = 1'b0;
      winModel  = 1'b0;
      scoreboard.delete();
   endtask

   // Values visible after edge e equal the gate results present at edge e+1,
   // so each tap looks back (delay - 1) edges along its path
   task automatic modelEdge(input logic [3:0] abcd, input logic clrIn);
      exp_t ex;
      logic yNow, inChg, yChg;
      histAb[edgeIdx] = abcd[3] & abcd[2];
      histC[edgeIdx]  = abcd[1];
      histD[edgeIdx]  = abcd[0];
      ex.n1 = abAt(edgeIdx + 1 - DA1);
      ex.n2 = abAt(edgeIdx + 1 - DA1 - DOR) | cAt(edgeIdx + 1 - DOR);
      yNow  = (abAt(edgeIdx + 1 - LAT) | cAt(edgeIdx + 1 - DOR - DA2)) & dAt(edgeIdx + 1 - DA2);
      ex.y  = yNow;
      inChg = (abcd != prevIn);
      prevIn = abcd;
      settleCnt = inChg ? 0 : ((settleCnt < LAT) ? settleCnt + 1 : LAT);
      ex.settled = (settleCnt == LAT);
      yChg = (yNow != yPrev);
      yPrev = yNow;
      if (yChg && togModel < 255) togModel++;
      if (yChg && !inChg && winModel) hazModel = 1'b1;
      if (inChg) winModel = 1'b0;
      else if (yChg) winModel = 1'b1;
      if (clrIn) begin
         togModel = 0;
         hazModel = 1'b0;
      end
      ex.tog = 8'(togModel);
      ex.haz = hazModel;
      scoreboard.push_back(ex);
      edgeIdx++;
   endtask

   // Pop the expected result for the edge just taken and compare every output
   task automatic checkOutput();
      exp_t ex;
      if (scoreboard.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      ex = scoreboard.pop_front();
      chk("n1", 32'(n1), 32'(ex.n1));
      chk("n2", 32'(n2), 32'(ex.n2));
      chk("y", 32'(y), 32'(ex.y));
      chk("settled", 32'(settled), 32'(ex.settled));
      chk("y_toggles", 32'(yToggles), 32'(ex.tog));
      chk("hazard", 32'(hazard), 32'(ex.haz));
   endtask

   // Drive one vector at the falling edge, take a rising edge, check after it
   task automatic applyStimulus(input logic [3:0] abcd, input logic clrIn);
      {a, b, c, d} = abcd;
      clr = clrIn;
      @(posedge clk);
      modelEdge(abcd, clrIn);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic holdVec(input logic [3:0] abcd, input int n);
      for (int i = 0; i < n; i++) applyStimulus(abcd, 1'b0);
   endtask

   // Directed sequence following the lab scenarios, then a random soak
   initial begin
      reset = 1'b1;
      {a, b, c, d} = 4'b0000;
      clr  = 1'b0;
      sa   = 2'b01;
      sb   = 2'b01;
      sc   = 2'b00;
      sd   = 2'b00;
      sClr = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      chk("reset_y", 32'(y), 32'd0);
      chk("reset_settled", 32'(settled), 32'd0);
      reset = 1'b0;

      // Quiet start: settled rises on the seventh edge
      holdVec(4'b0000, 6);
      chk("settle_edge6", 32'(settled), 32'd0);
      holdVec(4'b0000, 1);
      chk("settle_edge7", 32'(settled), 32'd1);
      holdVec(4'b0000, 2);

      // Rising path through all three gates
      holdVec(4'b1101, 7);
      chk("rise_y", 32'(y), 32'd1);
      chk("rise_unsettled", 32'(settled), 32'd0);
      holdVec(4'b1101, 2);
      chk("rise_settled", 32'(settled), 32'd1);
      chk("rise_tog", 32'(yToggles), 32'd1);

      // Long path fall, then short path fall
      holdVec(4'b0101, 6);
      chk("long_y_hold", 32'(y), 32'd1);
      holdVec(4'b0101, 1);
      chk("long_y_fall", 32'(y), 32'd0);
      holdVec(4'b0101, 2);
      holdVec(4'b1101, 9);
      holdVec(4'b1100, 1);
      chk("short_y_hold", 32'(y), 32'd1);
      holdVec(4'b1100, 1);
      chk("short_y_fall", 32'(y), 32'd0);
      holdVec(4'b1100, 7);
      chk("short_tog", 32'(yToggles), 32'd4);
      chk("short_hazard", 32'(hazard), 32'd0);

      // Static-1 hazard: c drops before n1 rises
      holdVec(4'b0111, 9);
      holdVec(4'b1101, 3);
      chk("haz_n2_low", 32'(n2), 32'd0);
      holdVec(4'b1101, 2);
      chk("haz_y_low", 32'(y), 32'd0);
      holdVec(4'b1101, 2);
      chk("haz_y_high", 32'(y), 32'd1);
      holdVec(4'b1101, 2);
      chk("haz_tog", 32'(yToggles), 32'd7);
      chk("haz_flag", 32'(hazard), 32'd1);
      applyStimulus(4'b1101, 1'b1);
      chk("clr_tog", 32'(yToggles), 32'd0);
      chk("clr_hazard", 32'(hazard), 32'd0);

      // Asynchronous reset with a transition in flight
      holdVec(4'b0000, 9);
      holdVec(4'b1101, 4);
      chk("pre_reset_n1", 32'(n1), 32'd1);
      reset = 1'b1;
      #1;
      chk("async_n1", 32'(n1), 32'd0);
      chk("async_n2", 32'(n2), 32'd0);
      chk("async_y", 32'(y), 32'd0);
      chk("async_settled", 32'(settled), 32'd0);
      chk("async_tog", 32'(yToggles), 32'd0);
      {a, b, c, d} = 4'b0000;
      @(negedge clk);
      reset = 1'b0;
      modelReset();
      holdVec(4'b0000, 10);
      chk("post_reset_y", 32'(y), 32'd0);
      chk("post_reset_tog", 32'(yToggles), 32'd0);

      // Random soak against the model
      for (int i = 0; i < 60; i++)
         applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));

      // Saturating counter on the narrow instance
      for (int i = 1; i <= 10; i++) begin
         sd[0] = ~sd[0];
         repeat (3) @(negedge clk);
         if (i == 1) chk("sat_y_first", 32'(sY), 32'd1);
         if (i == 2) chk("sat_tog2", 32'(sToggles), 32'd2);
      end
      chk("sat_tog", 32'(sToggles), 32'd3);
      chk("sat_hazard", 32'(sHazard), 32'd0);
      chk("sat_y_end", 32'(sY), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
